// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

  // Sweep-then-serve lifecycle of the register file.
  typedef enum logic {
    RF_INIT  = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

  // Default geometry, matching the legacy 32x64 datapath register file.
  localparam int RF_DATA_W   = 64;
  localparam int RF_NUM_REGS = 32;
  localparam int RF_ZR_IDX   = 31;
  localparam int RF_NUM_RD   = 2;
  localparam int RF_NUM_WR   = 1;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits used by decode for hazard detection.
// A reserve marks a register as having an in-flight producer; a write
// from writeback retires it. When both hit one register in the same
// cycle the reserve wins, because it names the newer producer.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int NUM_RD   = RF_NUM_RD,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       ready,
  input  logic [NUM_REGS-1:0]        set_vec,
  input  logic [NUM_REGS-1:0]        clr_vec,
  input  logic [NUM_REGS-1:0]        zr_mask,
  input  logic [NUM_RD-1:0][AW-1:0]  ra,
  input  logic [NUM_RD-1:0]          byp_clr,
  output logic [NUM_RD-1:0]          rd_busy
);

  logic [NUM_REGS-1:0] busy;

  // Busy flops: clear on retiring write, then set on reserve so a
  // same-cycle reserve overrides the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr_vec) | set_vec;
    end
  end

  // Busy lookup per read port; the zero register is never busy and a
  // bypassed write (without a competing reserve) already hides the hazard.
  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_busy[i] = ready && !zr_mask[ra[i]] && !byp_clr[i] && busy[ra[i]];
    end
  end

endmodule : regfile_scoreboard

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write-to-read bypass,
// busy scoreboard and a post-reset clearing sweep (storage has no reset).
//
// Interface contract: there is no handshake. Writes and reserves are
// accepted only while init_done is high; anything presented during the
// clearing sweep is dropped. Reads are combinational from ra.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int NUM_WR   = RF_NUM_WR,
  parameter bit ZR_EN    = 1'b1,
  parameter int ZR_IDX   = RF_ZR_IDX,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_WR-1:0]              we,
  input  logic [NUM_WR-1:0][AW-1:0]      wa,
  input  logic [NUM_WR-1:0][DATA_W-1:0]  wd,
  input  logic [NUM_RD-1:0][AW-1:0]      ra,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd,
  input  logic                           rsv_en,
  input  logic [AW-1:0]                  rsv_a,
  output logic [NUM_RD-1:0]              rd_busy,
  output logic                           init_done,
  output rf_state_t                      dbg_state
);

  localparam logic [AW-1:0] ZA       = AW'(ZR_IDX);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

  rf_state_t state;
  rf_state_t state_nx;
  logic [AW-1:0] cnt;
  logic ready;
  logic sweep_we;

  logic [DATA_W-1:0] mem [NUM_REGS];

  logic [NUM_WR-1:0]              we_eff;
  logic                           rsv_eff;
  logic [NUM_REGS-1:0]            clr_vec;
  logic [NUM_REGS-1:0]            set_vec;
  logic [NUM_REGS-1:0]            zr_mask;
  logic [NUM_RD-1:0]              byp_hit;
  logic [NUM_RD-1:0]              byp_clr;
  logic [NUM_RD-1:0][DATA_W-1:0]  byp_data;

  // True when the address is the hard-wired zero register.
  function automatic logic is_zr(input logic [AW-1:0] a);
    return ZR_EN && (a == ZA);
  endfunction

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RF_INIT;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next state: leave INIT once the last entry has been cleared.
  always_comb begin
    state_nx = state;
    case (state)
      RF_INIT:  if (cnt == LAST_IDX) state_nx = RF_READY;
      RF_READY: state_nx = RF_READY;
      default:  state_nx = RF_INIT;
    endcase
  end

  // FSM outputs.
  always_comb begin
    ready     = (state == RF_READY);
    sweep_we  = (state == RF_INIT);
    init_done = ready;
    dbg_state = state;
  end

  // Sweep counter: walks every entry once after reset, then holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (state == RF_INIT) begin
      cnt <= cnt + AW'(1);
    end
  end

  // Qualify writes/reserves: only in READY and never to the zero register.
  always_comb begin
    we_eff  = '0;
    rsv_eff = 1'b0;
    clr_vec = '0;
    set_vec = '0;
    zr_mask = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      we_eff[k] = ready && we[k] && !is_zr(wa[k]);
      if (we_eff[k]) clr_vec[wa[k]] = 1'b1;
    end
    rsv_eff = ready && rsv_en && !is_zr(rsv_a);
    if (rsv_eff) set_vec[rsv_a] = 1'b1;
    if (ZR_EN) zr_mask[ZA] = 1'b1;
  end

  // Storage array: sweep clears one entry per cycle, otherwise the write
  // ports update it; the higher-numbered port is applied last and wins.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[cnt] <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (we_eff[k]) mem[wa[k]] <= wd[k];
      end
    end
  end

  // Read path: zero register and INIT read 0; otherwise forward a
  // same-cycle write when bypass is enabled, else the stored value.
  always_comb begin
    byp_hit  = '0;
    byp_clr  = '0;
    byp_data = '0;
    rd       = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (BYPASS && we_eff[k] && (wa[k] == ra[i])) begin
          byp_hit[i]  = 1'b1;
          byp_data[i] = wd[k];
        end
      end
      byp_clr[i] = byp_hit[i] && !(rsv_eff && (rsv_a == ra[i]));
      if (!ready || is_zr(ra[i])) begin
        rd[i] = '0;
      end else if (byp_hit[i]) begin
        rd[i] = byp_data[i];
      end else begin
        rd[i] = mem[ra[i]];
      end
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD)
  ) u_scoreboard (
    .clk      (clk),
    .reset_n  (reset_n),
    .ready    (ready),
    .set_vec  (set_vec),
    .clr_vec  (clr_vec),
    .zr_mask  (zr_mask),
    .ra       (ra),
    .byp_clr  (byp_clr),
    .rd_busy  (rd_busy)
  );

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (2 read / 2 write ports, bypass and
// zero register enabled) against a behavioural register-file model.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DW  = 64;
  localparam int NR  = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int AWB = 5;
  localparam logic [AWB-1:0] ZR = 5'd31;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [NWR-1:0]           we;
  logic [NWR-1:0][AWB-1:0]  wa;
  logic [NWR-1:0][DW-1:0]   wd;
  logic [NRD-1:0][AWB-1:0]  ra;
  logic [NRD-1:0][DW-1:0]   rd;
  logic                     rsv_en;
  logic [AWB-1:0]           rsv_a;
  logic [NRD-1:0]           rd_busy;
  logic                     init_done;
  rf_state_t                dbg_state;

  regfile_mp #(
    .DATA_W   (DW),
    .NUM_REGS (NR),
    .NUM_RD   (NRD),
    .NUM_WR   (NWR),
    .ZR_EN    (1'b1),
    .ZR_IDX   (31),
    .BYPASS   (1'b1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .ra        (ra),
    .rd        (rd),
    .rsv_en    (rsv_en),
    .rsv_a     (rsv_a),
    .rd_busy   (rd_busy),
    .init_done (init_done),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] m_mem [NR];
  bit            m_busy [NR];
  bit            m_ready;
  int            m_sweep_left;

  task automatic model_reset();
    m_ready      = 1'b0;
    m_sweep_left = NR;
    for (int r = 0; r < NR; r++) m_busy[r] = 1'b0;
  endtask

  // Architectural effect of one rising edge with the inputs currently driven.
  task automatic model_edge();
    if (!reset_n) return;
    if (!m_ready) begin
      m_sweep_left--;
      if (m_sweep_left == 0) begin
        m_ready = 1'b1;
        for (int r = 0; r < NR; r++) m_mem[r] = '0;
      end
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (we[k] && wa[k] != ZR) begin
          m_mem[wa[k]]  = wd[k];
          m_busy[wa[k]] = 1'b0;
        end
      end
      if (rsv_en && rsv_a != ZR) m_busy[rsv_a] = 1'b1;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the model for the inputs now applied.
  task automatic check_outputs();
    logic [AWB-1:0] a;
    logic [DW-1:0]  ed;
    bit             eb;
    int             hit;
    exp_q.push_back(DW'(m_ready));
    exp_q.push_back(DW'(m_ready));
    for (int i = 0; i < NRD; i++) begin
      a = ra[i];
      if (!m_ready || a == ZR) begin
        ed = '0;
        eb = 1'b0;
      end else begin
        hit = -1;
        for (int k = 0; k < NWR; k++) if (we[k] && wa[k] == a) hit = k;
        if (hit >= 0) begin
          ed = wd[hit];
          eb = (rsv_en && rsv_a == a) ? m_busy[a] : 1'b0;
        end else begin
          ed = m_mem[a];
          eb = m_busy[a];
        end
      end
      exp_q.push_back(ed);
      exp_q.push_back(DW'(eb));
    end
    check("init_done", DW'(init_done), exp_q.pop_front());
    check("state_ready", DW'(dbg_state == RF_READY), exp_q.pop_front());
    for (int i = 0; i < NRD; i++) begin
      check($sformatf("rd%0d[r%0d]", i, ra[i]), rd[i], exp_q.pop_front());
      check($sformatf("busy%0d[r%0d]", i, ra[i]), DW'(rd_busy[i]), exp_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    we = '0; wa = '0; wd = '0; ra = '0; rsv_en = 1'b0; rsv_a = '0;
  endtask

  function automatic logic [AWB-1:0] rand_addr();
    return ($urandom_range(0, 1) == 0) ? AWB'($urandom_range(0, 7)) : AWB'($urandom_range(0, NR - 1));
  endfunction

  task automatic rand_inputs();
    we = NWR'($urandom_range(0, 3));
    for (int k = 0; k < NWR; k++) begin
      wa[k] = rand_addr();
      wd[k] = {$urandom, $urandom};
    end
    for (int i = 0; i < NRD; i++) ra[i] = rand_addr();
    rsv_en = ($urandom_range(0, 2) == 0);
    rsv_a  = rand_addr();
  endtask

  // Inputs are set at the falling edge; check mid-low-phase, then clock.
  task automatic run_cycle();
    #1 check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic assert_reset();
    reset_n = 1'b0;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  int n;

  initial begin
    idle();
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state, with traffic present
    rand_inputs();
    run_cycle();
    idle();
    ra[0] = 5'd23; ra[1] = 5'd7;
    run_cycle();

    // Release and sweep; a write on edge 5 must be dropped
    reset_n = 1'b1;
    for (int c = 1; c <= NR; c++) begin
      rand_inputs();
      if (c == 5) begin
        we = 2'b01; wa[0] = 5'd23; wd[0] = 64'd46;
      end
      run_cycle();
    end
    check("init_done_after_sweep", DW'(init_done), 64'd1);

    // Every register reads zero after the sweep
    for (int a = 0; a < NR; a += 2) begin
      idle();
      ra[0] = AWB'(a); ra[1] = AWB'(a + 1);
      run_cycle();
    end

    // Write r23 = 46 (bypass in same cycle), then we=0 with wd=96
    idle(); we = 2'b01; wa[0] = 5'd23; wd[0] = 64'd46; ra[0] = 5'd23; ra[1] = 5'd23;
    #1 check("r23_bypass", rd[0], 64'd46);
    run_cycle();
    idle(); wa[0] = 5'd23; wd[0] = 64'd96; ra[0] = 5'd23;
    #1 check("r23_held", rd[0], 64'd46);
    run_cycle();
    run_cycle();

    // Zero register: write and reserve dropped
    idle(); we = 2'b01; wa[0] = ZR; wd[0] = 64'd23; rsv_en = 1'b1; rsv_a = ZR; ra[0] = ZR;
    run_cycle();
    idle(); ra[0] = ZR;
    #1 check("zr_data", rd[0], 64'd0);
    run_cycle();

    // Both ports write r5: port 1 wins
    idle(); we = 2'b11; wa[0] = 5'd5; wa[1] = 5'd5; wd[0] = 64'hAA; wd[1] = 64'hBB; ra[0] = 5'd5;
    #1 check("r5_dual_bypass", rd[0], 64'hBB);
    run_cycle();
    idle(); ra[1] = 5'd5;
    #1 check("r5_dual_stored", rd[1], 64'hBB);
    run_cycle();

    // Reserve r7, retire with a write, then reserve+write together
    idle(); rsv_en = 1'b1; rsv_a = 5'd7; ra[0] = 5'd7;
    run_cycle();
    idle(); ra[0] = 5'd7;
    #1 check("r7_busy_set", DW'(rd_busy[0]), 64'd1);
    run_cycle();
    idle(); we = 2'b01; wa[0] = 5'd7; wd[0] = 64'd9; ra[0] = 5'd7;
    run_cycle();
    idle(); ra[0] = 5'd7;
    #1 check("r7_busy_clear", DW'(rd_busy[0]), 64'd0);
    run_cycle();
    idle(); we = 2'b01; wa[0] = 5'd7; wd[0] = 64'd9; rsv_en = 1'b1; rsv_a = 5'd7; ra[0] = 5'd7;
    run_cycle();
    idle(); ra[0] = 5'd7;
    #1 check("r7_rsv_wins", DW'(rd_busy[0]), 64'd1);
    run_cycle();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      rand_inputs();
      run_cycle();
    end

    // Reset after writes, then again mid-sweep at edge 10
    assert_reset();
    for (int c = 0; c < 2; c++) begin
      rand_inputs();
      run_cycle();
    end
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      rand_inputs();
      run_cycle();
    end
    assert_reset();
    rand_inputs();
    run_cycle();
    reset_n = 1'b1;
    n = 0;
    while (!init_done && n < 64) begin
      rand_inputs();
      run_cycle();
      n++;
    end
    check("sweep_len_after_reset", DW'(n), 64'd32);

    // Cleared contents after the restarted sweep, then more random traffic
    for (int a = 0; a < NR; a += 2) begin
      idle();
      ra[0] = AWB'(a); ra[1] = AWB'(a + 1);
      run_cycle();
    end
    for (int c = 0; c < 200; c++) begin
      rand_inputs();
      run_cycle();
    end

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog: the run is a fixed number of cycles, so this should never fire.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule : tb_regfile_mp

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file, successor to the fixed 2-read/1-write 32×64 `regfile` used by the datapath. It adds configurable width, depth and port counts, write-to-read bypass, per-register busy bits for pipeline hazard detection, and a post-reset clearing sweep so the storage array needs no reset flops. It sits between decode (reads, busy checks, destination reservation) and writeback (writes).

## Interface
- `DATA_W`, 64: register width in bits.
- `NUM_REGS`, 32: register count; power of two, ≥ 4.
- `NUM_RD`, 2: read ports, 1..4.
- `NUM_WR`, 1: write ports, 1..2.
- `ZR_EN`, 1: 1 = register `ZR_IDX` is hard-wired zero (XZR).
- `ZR_IDX`, 31: zero-register index.
- `BYPASS`, 1: 1 = same-cycle write data is forwarded to reads.
- Derived: `AW = $clog2(NUM_REGS)`.

Ports:
- `clk` in 1: clock; all state changes on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `we` in `NUM_WR`: per-port write enable.
- `wa` in `NUM_WR`×`AW`: write address.
- `wd` in `NUM_WR`×`DATA_W`: write data.
- `ra` in `NUM_RD`×`AW`: read address.
- `rd` out `NUM_RD`×`DATA_W`: read data, combinational.
- `rsv_en` in 1: reserve destination (set busy).
- `rsv_a` in `AW`: register to reserve.
- `rd_busy` out `NUM_RD`: busy bit of `ra[i]`, combinational.
- `init_done` out 1: high once the clearing sweep has finished.

## Operation
- States: `INIT` → `READY`. Reset forces `INIT` with sweep counter = 0, every busy bit = 0, and `init_done` = 0.
- `INIT`: each cycle writes 0 to entry `counter`, then increments the counter. After entry `NUM_REGS-1` is written, the FSM goes to `READY`.
- In `INIT`, `we` and `rsv_en` are ignored, `rd` reads 0 and `rd_busy` reads 0.
- `READY` is held until the next reset. Reset asserted mid-sweep or mid-operation returns to `INIT` at counter 0.
- Write: with `we[k]` high in `READY`, entry `wa[k]` takes `wd[k]` at the edge and its busy bit clears.
- Two ports writing the same address: port 1 wins.
- Reserve: with `rsv_en` high in `READY`, the busy bit of `rsv_a` sets at the edge.
- Reserve and write to the same register in one cycle: data is written and busy ends set (the new producer wins).
- Zero register (`ZR_EN`=1): writes and reserves to `ZR_IDX` are dropped. Reads of `ZR_IDX` always return 0 with busy 0, including under bypass.
- Read with `BYPASS`=1: if any `we[k]` targets `ra[i]` (not ZR) this cycle, `rd[i]` = `wd[k]` (port 1 has priority) and `rd_busy[i]` = 0, unless the same cycle also reserves that register.
- Read with `BYPASS`=0: `rd[i]` is the stored value, and the written value is visible from the next cycle.
- Addresses ≥ `NUM_REGS` cannot occur because `NUM_REGS` is a power of two.

## Timing
- Read latency is 0 cycles (combinational from `ra`). Write latency is 1 edge. Busy set and clear take 1 edge.
- The sweep lasts exactly `NUM_REGS` rising edges after `reset_n` deasserts. `init_done` rises after edge `NUM_REGS` (32 for the default).
- Reset values: `init_done` = 0, `rd_busy` = 0, `rd` = 0 while in `INIT`. The array contents are undefined until cleared by the sweep.
- No handshake: callers must hold writes and reserves until `init_done` = 1, otherwise they are silently lost.

## Structure
- Package `regfile_pkg`:
  - `rf_state_t` enum {`RF_INIT`, `RF_READY`}.
  - Default parameter constants: `RF_DATA_W`, `RF_NUM_REGS`, `RF_ZR_IDX`.
- Sub-module `regfile_scoreboard`:
  - Holds the `NUM_REGS` busy flops.
  - Inputs: reserve, the write-clear vector and the ZR mask.
  - Outputs: `rd_busy`.
- The top level holds the FSM, the sweep counter, the storage array and the read/bypass muxing.

## Test plan
- Reset release, default parameters → `init_done` low for 32 edges, then high. Every `ra` reads 0 at edge 33. A write of 46 to r23 on edge 5 is lost, so r23 still reads 0.
- `READY`, write r23 = 46 with `we`=1, then `wd`=96 with `we`=0 → r23 reads 46, then stays 46. With `BYPASS`=1, `rd` shows 46 in the write cycle itself.
- Write r31 = 23 with `ZR_EN`=1 → `rd` for r31 = 0 and `rd_busy` = 0. With `ZR_EN`=0, r31 reads 23 on the next cycle.
- `NUM_WR`=2, both ports write r5 (port0 = 0xAA, port1 = 0xBB) → r5 reads 0xBB. With `BYPASS`=1, 0xBB appears in the same cycle.
- Reserve r7 → `rd_busy` = 1 from the next cycle. Write r7 = 9 → busy clears and data is 9 after the edge (0 same-cycle under bypass). Simultaneous reserve and write of r7 → busy stays 1 and data is 9.
- Assert `reset_n` low mid-sweep (edge 10) and after writes → `init_done` = 0, busy all 0, and the sweep restarts at counter 0, completing 32 edges after release.
